// File: rtl/stream_scoreboard_if.sv
// Expected-word and DUT-word valid/ready streams feeding the scoreboard.
// master drives the words, slave (the scoreboard) returns the readies.
interface stream_scoreboard_if #(
    parameter int DATA_W = 32
);
    logic              exp_valid;
    logic              exp_ready;
    logic [DATA_W-1:0] exp_data;
    logic              act_valid;
    logic              act_ready;
    logic [DATA_W-1:0] act_data;

    modport master (
        output exp_valid, exp_data, act_valid, act_data,
        input  exp_ready, act_ready
    );

    modport slave (
        input  exp_valid, exp_data, act_valid, act_data,
        output exp_ready, act_ready
    );
endinterface

// File: rtl/stream_scoreboard.sv
// In-order checker of a DUT stream against a FIFO of expected words; compare result lands 1 cycle after accept.
// DUT side is never backpressured while running; expected side stalls when the FIFO is full; both stall once done.
module stream_scoreboard #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     finish,
    stream_scoreboard_if.slave       bus,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         fail_cnt,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     cmp_pulse,
    output logic                     cmp_ok,
    output logic                     unexpected,
    output logic                     ff_valid,
    output logic [CNT_W-1:0]         ff_idx,
    output logic [DATA_W-1:0]        ff_exp,
    output logic [DATA_W-1:0]        ff_act,
    output logic                     done,
    output logic                     all_pass
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

    logic [0:0]        state;
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  act_idx;

    logic              run;
    logic              empty;
    logic              full;
    logic              exp_acc;
    logic              act_acc;
    logic              push;
    logic              pop;
    logic              have_exp;
    logic [DATA_W-1:0] cmp_exp;
    logic              ok_d;

    assign run     = (state == ST_RUN);
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pending = wr_ptr - rd_ptr;

    assign bus.exp_ready = run && !full;
    assign bus.act_ready = run;

    assign exp_acc = bus.exp_valid && bus.exp_ready;
    assign act_acc = bus.act_valid && bus.act_ready;

    // An expected word meeting a DUT word at an empty FIFO is compared directly and never stored.
    assign push     = exp_acc && !(act_acc && empty) && !clear;
    assign pop      = act_acc && !empty;
    assign have_exp = !empty || exp_acc;
    assign cmp_exp  = !empty ? mem[rd_ptr[AW-1:0]] : (exp_acc ? bus.exp_data : '0);
    assign ok_d     = have_exp && (cmp_exp == bus.act_data);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= bus.exp_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            act_idx    <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            cmp_pulse  <= 1'b0;
            cmp_ok     <= 1'b0;
            unexpected <= 1'b0;
            ff_valid   <= 1'b0;
            ff_idx     <= '0;
            ff_exp     <= '0;
            ff_act     <= '0;
            done       <= 1'b0;
            all_pass   <= 1'b0;
        end else if (clear) begin
            state      <= ST_RUN;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            act_idx    <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            cmp_pulse  <= 1'b0;
            cmp_ok     <= 1'b0;
            unexpected <= 1'b0;
            ff_valid   <= 1'b0;
            ff_idx     <= '0;
            ff_exp     <= '0;
            ff_act     <= '0;
            done       <= 1'b0;
            all_pass   <= 1'b0;
        end else begin
            cmp_pulse <= act_acc;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            if (act_acc) begin
                cmp_ok  <= ok_d;
                act_idx <= act_idx + 1'b1;
                if (ok_d) begin
                    if (pass_cnt != '1)
                        pass_cnt <= pass_cnt + 1'b1;
                end else begin
                    if (fail_cnt != '1)
                        fail_cnt <= fail_cnt + 1'b1;
                    if (!ff_valid) begin
                        ff_valid <= 1'b1;
                        ff_idx   <= act_idx;
                        ff_exp   <= cmp_exp;
                        ff_act   <= bus.act_data;
                    end
                end
                if (!have_exp)
                    unexpected <= 1'b1;
            end

            if (run && finish)
                state <= ST_DONE;

            // Nothing is accepted in DONE, so the counters sampled here already include the last compare.
            if (!run && !done) begin
                done     <= 1'b1;
                all_pass <= (fail_cnt == '0) && (pending == '0) && !unexpected;
            end
        end
    end
endmodule

// File: tb/tb_stream_scoreboard.sv
// Randomized and directed bench for stream_scoreboard against a queue-based reference model.
module tb_stream_scoreboard;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 16;
    localparam int PW     = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic finish;

    stream_scoreboard_if #(.DATA_W(DATA_W)) bus ();

    logic [CNT_W-1:0]  pass_cnt, fail_cnt, ff_idx;
    logic [PW-1:0]     pending;
    logic              cmp_pulse, cmp_ok, unexpected, ff_valid, done, all_pass;
    logic [DATA_W-1:0] ff_exp, ff_act;

    stream_scoreboard #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .finish(finish), .bus(bus),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .pending(pending),
        .cmp_pulse(cmp_pulse), .cmp_ok(cmp_ok), .unexpected(unexpected),
        .ff_valid(ff_valid), .ff_idx(ff_idx), .ff_exp(ff_exp), .ff_act(ff_act),
        .done(done), .all_pass(all_pass)
    );

    // Narrow-counter instance for saturation.
    stream_scoreboard_if #(.DATA_W(DATA_W)) bus2 ();
    logic             clear2;
    logic             finish2;
    logic [3:0]       pass2, fail2, ff_idx2;
    logic [2:0]       pending2;
    logic             pulse2, ok2, unexp2, ffv2, done2, all2;
    logic [DATA_W-1:0] ff_exp2, ff_act2;

    stream_scoreboard #(.DATA_W(DATA_W), .DEPTH(4), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear2), .finish(finish2), .bus(bus2),
        .pass_cnt(pass2), .fail_cnt(fail2), .pending(pending2),
        .cmp_pulse(pulse2), .cmp_ok(ok2), .unexpected(unexp2),
        .ff_valid(ffv2), .ff_idx(ff_idx2), .ff_exp(ff_exp2), .ff_act(ff_act2),
        .done(done2), .all_pass(all2)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: a queue of outstanding expected words plus the reported statistics.
    logic [DATA_W-1:0] m_q[$];
    logic [CNT_W-1:0]  m_pass, m_fail, m_idx, m_ff_idx;
    logic [DATA_W-1:0] m_ff_exp, m_ff_act;
    logic              m_unexp, m_ffv, m_pulse, m_ok, m_stopped, m_done, m_all;

    task automatic model_reset();
        m_q.delete();
        m_pass = '0; m_fail = '0; m_idx = '0; m_ff_idx = '0;
        m_ff_exp = '0; m_ff_act = '0;
        m_unexp = 0; m_ffv = 0; m_pulse = 0; m_ok = 0;
        m_stopped = 0; m_done = 0; m_all = 0;
    endtask

    function automatic logic m_exp_rdy();
        return !m_stopped && (m_q.size() < DEPTH);
    endfunction

    task automatic model_next(input logic ev, input logic [DATA_W-1:0] ed,
                              input logic av, input logic [DATA_W-1:0] ad,
                              input logic fin, input logic clr);
        logic ea, aa, have, bypass, ok;
        logic [DATA_W-1:0] w;
        if (clr) begin
            model_reset();
            return;
        end
        ea = ev && m_exp_rdy();
        aa = av && !m_stopped;
        if (m_stopped && !m_done) begin
            m_done = 1;
            m_all  = (m_fail == 0) && (m_q.size() == 0) && !m_unexp;
        end
        m_pulse = aa;
        bypass  = 0;
        if (aa) begin
            have = 1;
            if (m_q.size() > 0) begin
                w = m_q.pop_front();
            end else if (ea) begin
                w = ed;
                bypass = 1;
            end else begin
                w = '0;
                have = 0;
            end
            ok   = have && (w == ad);
            m_ok = ok;
            if (ok) begin
                if (m_pass != {CNT_W{1'b1}}) m_pass = m_pass + 1;
            end else begin
                if (m_fail != {CNT_W{1'b1}}) m_fail = m_fail + 1;
                if (!m_ffv) begin
                    m_ffv = 1; m_ff_idx = m_idx; m_ff_exp = w; m_ff_act = ad;
                end
            end
            if (!have) m_unexp = 1;
            m_idx = m_idx + 1;
        end
        if (ea && !bypass) m_q.push_back(ed);
        if (fin) m_stopped = 1;
    endtask

    task automatic check_outputs();
        chk("exp_ready", bus.exp_ready, m_exp_rdy());
        chk("act_ready", bus.act_ready, !m_stopped);
        chk("pass_cnt", pass_cnt, m_pass);
        chk("fail_cnt", fail_cnt, m_fail);
        chk("pending", pending, m_q.size());
        chk("cmp_pulse", cmp_pulse, m_pulse);
        if (m_pulse) chk("cmp_ok", cmp_ok, m_ok);
        chk("unexpected", unexpected, m_unexp);
        chk("ff_valid", ff_valid, m_ffv);
        chk("ff_idx", ff_idx, m_ff_idx);
        chk("ff_exp", ff_exp, m_ff_exp);
        chk("ff_act", ff_act, m_ff_act);
        chk("done", done, m_done);
        chk("all_pass", all_pass, m_all);
    endtask

    // Called at a falling edge: drive, let one rising edge pass, check at the next falling edge.
    task automatic step(input logic ev, input logic [DATA_W-1:0] ed,
                        input logic av, input logic [DATA_W-1:0] ad,
                        input logic fin, input logic clr);
        bus.exp_valid = ev; bus.exp_data = ed;
        bus.act_valid = av; bus.act_data = ad;
        finish = fin; clear = clr;
        model_next(ev, ed, av, ad, fin, clr);
        @(posedge clk);
        @(negedge clk);
        bus.exp_valid = 0; bus.act_valid = 0; finish = 0; clear = 0;
        check_outputs();
    endtask

    task automatic push(input logic [DATA_W-1:0] d);  step(1, d, 0, '0, 0, 0); endtask
    task automatic send(input logic [DATA_W-1:0] d);  step(0, '0, 1, d, 0, 0); endtask
    task automatic idle();                            step(0, '0, 0, '0, 0, 0); endtask
    task automatic do_finish();                       step(0, '0, 0, '0, 1, 0); endtask
    task automatic do_clear();                        step(0, '0, 0, '0, 0, 1); endtask

    initial begin
        int pushed;
        int acts;
        logic ev, av, fin, mis;
        logic [DATA_W-1:0] ed, ad;

        rst_n = 0; clear = 0; finish = 0; clear2 = 0; finish2 = 0;
        bus.exp_valid = 0; bus.exp_data = '0; bus.act_valid = 0; bus.act_data = '0;
        bus2.exp_valid = 0; bus2.exp_data = '0; bus2.act_valid = 0; bus2.act_data = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1;
        @(negedge clk);

        // Matching stream
        push(32'h11); push(32'h22); push(32'h33);
        send(32'h11); send(32'h22); send(32'h33);
        do_finish(); idle(); idle();
        chk("s1_pass_cnt", pass_cnt, 3);
        chk("s1_all_pass", all_pass, 1);
        chk("s1_done", done, 1);

        // Two mismatches, first one recorded
        do_clear();
        push(32'hA); push(32'hB); push(32'hC);
        send(32'hA); send(32'hF); send(32'hD);
        do_finish(); idle(); idle();
        chk("s2_fail_cnt", fail_cnt, 2);
        chk("s2_ff_idx", ff_idx, 1);
        chk("s2_ff_exp", ff_exp, 32'hB);
        chk("s2_ff_act", ff_act, 32'hF);
        chk("s2_all_pass", all_pass, 0);

        // Fill, blocked push while full, then stream through with pointer wrap
        do_clear();
        for (int i = 0; i < DEPTH; i++) push(32'h100 + i);
        chk("s3_full_rdy", bus.exp_ready, 0);
        chk("s3_full_pending", pending, DEPTH);
        step(1, 32'hDEAD, 1, m_q[0], 0, 0);
        chk("s3_blocked_pending", pending, DEPTH - 1);
        pushed = 0;
        for (int i = 0; i < 400 && (pushed < 40 || m_q.size() > 0); i++) begin
            ev = (pushed < 40) && ($urandom_range(0, 3) != 0);
            av = (m_q.size() > 0) && ($urandom_range(0, 3) != 0);
            ed = 32'h200 + pushed;
            ad = (m_q.size() > 0) ? m_q[0] : '0;
            if (ev && m_exp_rdy()) pushed++;
            step(ev, ed, av, ad, 0, 0);
        end
        chk("s3_pass_cnt", pass_cnt, DEPTH + 40);
        chk("s3_fail_cnt", fail_cnt, 0);
        do_finish(); idle(); idle();
        chk("s3_all_pass", all_pass, 1);

        // Unexpected word, then same-cycle bypass
        do_clear();
        send(32'h77);
        chk("s4_unexpected", unexpected, 1);
        chk("s4_fail_cnt", fail_cnt, 1);
        chk("s4_ff_exp", ff_exp, 0);
        step(1, 32'h5, 1, 32'h5, 0, 0);
        chk("s4_bypass_ok", cmp_ok, 1);
        chk("s4_bypass_pending", pending, 0);

        // Leftover expected word fails the verdict; DONE stalls both sides
        do_clear();
        push(32'h1); push(32'h2); send(32'h1);
        do_finish(); idle(); idle();
        chk("s5_pending", pending, 1);
        chk("s5_all_pass", all_pass, 0);
        chk("s5_exp_ready", bus.exp_ready, 0);
        chk("s5_act_ready", bus.act_ready, 0);
        send(32'h2);
        chk("s5_no_accept", pass_cnt, 1);

        // Random traffic with occasional mismatches, finish and clear
        do_clear();
        for (int i = 0; i < 1500; i++) begin
            if (m_done) begin
                do_clear();
                continue;
            end
            ev  = $urandom_range(0, 99) < 55;
            av  = $urandom_range(0, 99) < 50;
            ed  = $urandom;
            mis = $urandom_range(0, 99) < 5;
            if (m_q.size() > 0) ad = mis ? $urandom : m_q[0];
            else                ad = (ev && !mis) ? ed : $urandom;
            fin = $urandom_range(0, 149) == 0;
            step(ev, ed, av, ad, fin, 0);
        end

        // Async reset mid-stream
        for (int i = 0; i < 6; i++) step(1, 32'h300 + i, i > 2, 32'h300 + i - 3, 0, 0);
        #2 rst_n = 0;
        #1 model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1;
        check_outputs();

        // Sync clear mid-stream, with traffic on the same cycle
        for (int i = 0; i < 5; i++) step(1, 32'h400 + i, i > 1, 32'h4FF, 0, 0);
        step(1, 32'h500, 1, 32'h500, 1, 1);
        chk("clr_pass_cnt", pass_cnt, 0);
        chk("clr_fail_cnt", fail_cnt, 0);
        chk("clr_pending", pending, 0);

        // Saturation on the 4-bit instance
        for (int i = 0; i < 20; i++) begin
            bus2.exp_valid = 1; bus2.exp_data = 32'h600 + i;
            bus2.act_valid = 1; bus2.act_data = 32'h600 + i;
            @(posedge clk);
            @(negedge clk);
            if (i == 9)  chk("sat_mid", pass2, 10);
            if (i == 14) chk("sat_reach", pass2, 15);
        end
        bus2.exp_valid = 0; bus2.act_valid = 0;
        chk("sat_pass_cnt", pass2, 15);
        chk("sat_fail_cnt", fail2, 0);
        chk("sat_pending", pending2, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
